// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the DataMemory arbiter.
//   state_t        - access sequencer states
//   PORT_CPU/DMA   - requester indices (port 0 = CPU MEM stage, port 1 = DMA/loader)
//   DEF_*          - default widths and memory latency
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MEM_LATENCY = 2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker (purely combinational).
//   req0, req1  in  - requests
//   last_grant  in  - port that won the previous arbitration
//   valid       out - at least one request present
//   winner      out - index of the chosen port
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);
    assign valid  = req0 | req1;
    // On a tie the port that did not win last time goes first.
    assign winner = (req0 && req1) ? ~last_grant : req1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer for the single-port DataMemory.
//   clk, rst_n                      - clock, asynchronous active-low reset
//   req/we/addr/wdata{0,1}          - requester side; port 0 = CPU, port 1 = DMA
//   ack{0,1}, rdata{0,1}            - one-cycle completion pulse and held read result
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata - DataMemory interface
//   busy, grant                     - sequencer active, current/last granted port
//   Optional DMEM_ARB_PERF_EN: adds saturating gnt_cnt0, gnt_cnt1, wait_cnt outputs.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1,
    output logic [31:0]       wait_cnt
`endif
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    state_t             state, state_nxt;
    logic               last_grant;
    logic               we_lat;
    logic [CNT_W-1:0]   cnt;
    logic               arb_valid;
    logic               arb_winner;
    logic               last_cycle;

    rr_arb2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign last_cycle = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE)   ? (arb_valid  ? ACCESS : IDLE) :
                    (state == ACCESS) ? (last_cycle ? DONE   : ACCESS) : IDLE;
        ack0      = (state == DONE) && (grant == PORT_CPU);
        ack1      = (state == DONE) && (grant == PORT_DMA);
        busy      = (state == ACCESS) || (state == DONE);
    end

    // Memory-side lines are registered at grant and held until the last ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            we_lat     <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (state == IDLE && arb_valid) begin
                grant     <= arb_winner;
                we_lat    <= arb_winner ? we1 : we0;
                mem_addr  <= arb_winner ? addr1 : addr0;
                mem_wdata <= arb_winner ? wdata1 : wdata0;
                mem_read  <= ~(arb_winner ? we1 : we0);
                mem_write <= arb_winner ? we1 : we0;
                cnt       <= CNT_W'(MEM_LATENCY - 1);
            end
            if (state == ACCESS) begin
                if (cnt == '0) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (!we_lat && grant == PORT_CPU) rdata0 <= mem_rdata;
                    if (!we_lat && grant == PORT_DMA) rdata1 <= mem_rdata;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (state == DONE) last_grant <= grant;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // A port is waiting when it requests but is not the one being served.
    logic waiting;
    assign waiting = (req0 && !(busy && grant == PORT_CPU)) ||
                     (req1 && !(busy && grant == PORT_DMA));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
            wait_cnt <= '0;
        end else begin
            if (ack0 && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (ack1 && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
            if (waiting && !(&wait_cnt)) wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small behavioural DataMemory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy, grant;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant     (grant)
`ifdef DMEM_ARB_PERF_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
        .wait_cnt  (wait_cnt)
`endif
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        {req0, req1, we0, we1} = 4'b0;
        {addr0, addr1, wdata0, wdata1} = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one request and measures it; ack_cyc counts the drive cycle as cycle 1 (0 = no ack).
    task automatic run_one(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output int ack_cyc, output int rd_n, output int wr_n,
                           output int other_ack, output int addr_bad);
        ack_cyc = 0; rd_n = 0; wr_n = 0; other_ack = 0; addr_bad = 0;
        @(negedge clk);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_read) rd_n++;
            if (mem_write) wr_n++;
            if ((mem_read || mem_write) && mem_addr !== a) addr_bad++;
            if (p ? ack0 : ack1) other_ack++;
            if (k == 1) begin
                if (p) begin addr1 = a ^ 32'h100; wdata1 = ~d; end
                else   begin addr0 = a ^ 32'h100; wdata0 = ~d; end
            end
            if (p ? ack1 : ack0) begin
                ack_cyc = k + 1;
                if (p) req1 = 1'b0; else req0 = 1'b0;
                break;
            end
        end
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {req0, req1, we0, we1} = 4'b0;
        {addr0, addr1, wdata0, wdata1} = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ack0, ack1, busy, grant, mem_read, mem_write} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, busy, grant, mem_read, mem_write});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rdata0, rdata1} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero", mem_addr, mem_wdata, rdata0, rdata1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int ac, rd, wr, oth, bad;
        run_one(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, ac, rd, wr, oth, bad);
        n_checks++;
        if (ac !== 4) begin n_fail++; $display("FAIL write_ack_cycle: got %0d expected 4", ac); end
        n_checks++;
        if (wr !== 2 || rd !== 0) begin n_fail++; $display("FAIL write_strobes: got wr=%0d rd=%0d expected wr=2 rd=0", wr, rd); end
        n_checks++;
        if (oth !== 0 || bad !== 0) begin n_fail++; $display("FAIL write_ack1_addr: got ack1=%0d addr_bad=%0d expected 0 0", oth, bad); end
        n_checks++;
        if (mem[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_mem: got %h expected deadbeef", mem[0]); end
        n_checks++;
        if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL write_rdata0: got %h expected 0", rdata0); end
    endtask

    task automatic test_read();
        int ac, rd, wr, oth, bad;
        run_one(1'b1, 1'b0, 32'h0, 32'h0, ac, rd, wr, oth, bad);
        n_checks++;
        if (ac !== 4) begin n_fail++; $display("FAIL read1_ack_cycle: got %0d expected 4", ac); end
        n_checks++;
        if (rd !== 2 || wr !== 0 || bad !== 0 || oth !== 0) begin
            n_fail++;
            $display("FAIL read1_strobes: got rd=%0d wr=%0d addr_bad=%0d ack0=%0d expected 2 0 0 0", rd, wr, bad, oth);
        end
        n_checks++;
        if (rdata1 !== 32'hDEADBEEF || rdata0 !== 32'h0 || grant !== 1'b1) begin
            n_fail++;
            $display("FAIL read1_data: got rdata1=%h rdata0=%h grant=%b expected deadbeef 0 1", rdata1, rdata0, grant);
        end
        run_one(1'b1, 1'b1, 32'h8, 32'h12345678, ac, rd, wr, oth, bad);
        run_one(1'b0, 1'b0, 32'h8, 32'h0, ac, rd, wr, oth, bad);
        n_checks++;
        if (rdata0 !== 32'h12345678 || rdata1 !== 32'hDEADBEEF || ac !== 4) begin
            n_fail++;
            $display("FAIL read0_data: got rdata0=%h rdata1=%h ack_cyc=%0d expected 12345678 deadbeef 4", rdata0, rdata1, ac);
        end
    endtask

    task automatic test_alternate();
        int seq [4];
        int n_ack = 0, viol = 0, t_prev = 0, gap = 0;
        apply_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h0; addr1 = 32'h8;
        for (int k = 1; k <= 40 && n_ack < 4; k++) begin
            @(negedge clk);
            if (ack0 && ack1) viol++;
            if (mem_read && mem_write) viol++;
            if (ack0 || ack1) begin
                seq[n_ack] = ack1 ? 1 : 0;
                if (n_ack == 3) gap = k - t_prev;
                t_prev = k;
                n_ack++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_checks++;
        if (n_ack !== 4) begin n_fail++; $display("FAIL alt_ack_count: got %0d expected 4", n_ack); end
        else begin
            n_checks++;
            if (seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
                n_fail++;
                $display("FAIL alt_order: got %0d%0d%0d%0d expected 0101", seq[0], seq[1], seq[2], seq[3]);
            end
            n_checks++;
            if (gap !== 4) begin n_fail++; $display("FAIL alt_ack_spacing: got %0d expected 4", gap); end
        end
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL alt_exclusive: got %0d overlap cycles expected 0", viol); end
        @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
        n_checks++;
        if (gnt_cnt0 !== 32'd2 || gnt_cnt1 !== 32'd2 || wait_cnt == 32'd0) begin
            n_fail++;
            $display("FAIL perf_counts: got g0=%0d g1=%0d wait=%0d expected 2 2 >0", gnt_cnt0, gnt_cnt1, wait_cnt);
        end
`endif
        repeat (4) @(negedge clk);
    endtask

    task automatic test_drop();
        int n_ack0 = 0, n_busy = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        @(negedge clk);
        if (busy) n_busy++;
        req0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (ack0) n_ack0++;
        end
        n_checks++;
        if (n_ack0 !== 1) begin n_fail++; $display("FAIL drop_ack0: got %0d expected 1", n_ack0); end
        n_checks++;
        if (n_busy !== 3) begin n_fail++; $display("FAIL drop_busy_cycles: got %0d expected 3", n_busy); end
    endtask

    task automatic test_reset_mid();
        int n_ack1 = 0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || mem_write !== 1'b1 || grant !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_in_access: got busy=%b mem_write=%b grant=%b expected 1 1 1", busy, mem_write, grant);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack0, ack1, busy, grant, mem_read, mem_write} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async_clear: got ctrl=%b addr=%h wdata=%h expected 0", {ack0, ack1, busy, grant, mem_read, mem_write}, mem_addr, mem_wdata);
        end
        req1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack1) n_ack1++;
        end
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h0; addr1 = 32'h0;
        n_checks++;
        if (n_ack1 !== 0 || mem[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_aborted: got ack1=%0d mem4=%h expected 0 00000000", n_ack1, mem[1]);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || grant !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_tie_after: got busy=%b grant=%b expected 1 0", busy, grant);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
